// File: rtl/fu_branch_pipe.sv
// Branch/jump functional unit. Resolves condition, target, link address and
// misprediction at accept, then carries the result through a LATENCY-deep
// valid/ready pipeline to the common data bus arbiter.
module fu_branch_pipe #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             jalr,
  input  logic [2:0]       cmp_ctrl,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  pc,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  input  logic [TAG_W-1:0] tag_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic             taken,
  output logic [XLEN-1:0]  pc_jump,
  output logic [XLEN-1:0]  pc_wb,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             busy
);

  // Condition evaluation; LT/GE are signed, LTU/GEU unsigned.
  function automatic logic f_cond(input logic [2:0] c,
                                  input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic                   res;
    sa = a;
    sb = b;
    case (c)
      3'b000:  res = 1'b0;
      3'b001:  res = (a == b);
      3'b010:  res = (a != b);
      3'b011:  res = (sa < sb);
      3'b100:  res = !(sa < sb);
      3'b101:  res = (a < b);
      3'b110:  res = !(a < b);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  // Per-stage valid bits and resolved payload
  logic [LATENCY-1:0] r_vld;
  logic [TAG_W-1:0]   r_tag   [LATENCY];
  logic               r_taken [LATENCY];
  logic               r_misp  [LATENCY];
  logic [XLEN-1:0]    r_jump  [LATENCY];
  logic [XLEN-1:0]    r_wb    [LATENCY];
  logic [XLEN-1:0]    r_redir [LATENCY];

  logic [LATENCY-1:0] w_adv;
  logic [LATENCY-1:0] w_inc;
  logic [LATENCY-1:0] w_vld_nxt;
  logic               w_rdy;
  logic               w_acc;
  logic [XLEN-1:0]    w_sum;
  logic [XLEN-1:0]    w_jump;
  logic [XLEN-1:0]    w_wb;
  logic               w_taken;
  logic               w_misp;

  // Resolve the op from the values presented in the accept cycle
  always_comb begin
    w_sum   = (jalr ? rs1_data : pc) + imm;
    w_jump  = jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
    w_wb    = pc + XLEN'(4);
    w_taken = f_cond(cmp_ctrl, rs1_data, rs2_data);
    w_misp  = (w_taken != pred_taken) |
              (w_taken & pred_taken & (w_jump != pred_target));
  end

  // Stall chain: a stage moves when everything downstream of it can make room
  always_comb begin
    logic [LATENCY:0] free;
    free          = '0;
    w_adv         = '0;
    free[LATENCY] = res_ready;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      w_adv[i] = r_vld[i] & free[i+1];
      free[i]  = ~r_vld[i] | w_adv[i];
    end
    w_rdy = free[0];
  end

  assign w_acc = issue_valid & w_rdy & ~flush;
  // Bit i is set when stage i receives an op this cycle
  assign w_inc = (w_adv << 1) | LATENCY'(w_acc);

  // Next valid state; flush empties every stage
  always_comb begin
    w_vld_nxt = w_inc | (r_vld & ~w_adv);
    if (flush) w_vld_nxt = '0;
  end

  // Pipeline registers: stage 0 captures at accept, later stages shift forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tag[i]   <= '0;
        r_taken[i] <= 1'b0;
        r_misp[i]  <= 1'b0;
        r_jump[i]  <= '0;
        r_wb[i]    <= '0;
        r_redir[i] <= '0;
      end
    end else begin
      r_vld <= w_vld_nxt;
      if (w_acc) begin
        r_tag[0]   <= tag_in;
        r_taken[0] <= w_taken;
        r_misp[0]  <= w_misp;
        r_jump[0]  <= w_jump;
        r_wb[0]    <= w_wb;
        r_redir[0] <= w_taken ? w_jump : w_wb;
      end
      for (int i = 1; i < LATENCY; i++) begin
        if (w_inc[i]) begin
          r_tag[i]   <= r_tag[i-1];
          r_taken[i] <= r_taken[i-1];
          r_misp[i]  <= r_misp[i-1];
          r_jump[i]  <= r_jump[i-1];
          r_wb[i]    <= r_wb[i-1];
          r_redir[i] <= r_redir[i-1];
        end
      end
    end
  end

  assign issue_ready = w_rdy;
  assign res_valid   = r_vld[LATENCY-1];
  assign res_tag     = r_tag[LATENCY-1];
  assign taken       = r_taken[LATENCY-1];
  assign mispredict  = r_misp[LATENCY-1];
  assign pc_jump     = r_jump[LATENCY-1];
  assign pc_wb       = r_wb[LATENCY-1];
  assign redirect_pc = r_redir[LATENCY-1];
  assign busy        = |r_vld;

endmodule

// File: tb/tb_fu_branch_pipe.sv
// Bench for fu_branch_pipe (XLEN=32, LATENCY=2, TAG_W=4): scenario tasks plus
// a scoreboard that predicts each accepted op and checks it at delivery.
module tb_fu_branch_pipe;
  logic        clk = 0;
  logic        rst_n = 1;
  logic        flush = 0;
  logic        issue_valid = 0;
  logic        issue_ready;
  logic        jalr = 0;
  logic [2:0]  cmp_ctrl = 0;
  logic [31:0] rs1_data = 0, rs2_data = 0, imm = 0, pc = 0;
  logic        pred_taken = 0;
  logic [31:0] pred_target = 0;
  logic [3:0]  tag_in = 0;
  logic        res_valid;
  logic        res_ready = 1;
  logic [3:0]  res_tag;
  logic        taken;
  logic [31:0] pc_jump, pc_wb, redirect_pc;
  logic        mispredict;
  logic        busy;

  int total = 0;
  int bad = 0;
  int n_deliv = 0;
  logic mon_en = 0;

  typedef struct {
    logic [3:0]  tag;
    logic        tk;
    logic [31:0] pj;
    logic [31:0] pw;
    logic        mp;
    logic [31:0] rd;
  } exp_t;
  exp_t q[$];

  fu_branch_pipe #(.XLEN(32), .LATENCY(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .jalr(jalr), .cmp_ctrl(cmp_ctrl),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .tag_in(tag_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .taken(taken), .pc_jump(pc_jump), .pc_wb(pc_wb),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model();
    exp_t e;
    logic lt;
    lt = ($signed(rs1_data) < $signed(rs2_data));
    e.tag = tag_in;
    case (cmp_ctrl)
      3'd0: e.tk = 1'b0;
      3'd1: e.tk = (rs1_data == rs2_data);
      3'd2: e.tk = (rs1_data != rs2_data);
      3'd3: e.tk = lt;
      3'd4: e.tk = !lt;
      3'd5: e.tk = (rs1_data < rs2_data);
      3'd6: e.tk = (rs1_data >= rs2_data);
      default: e.tk = 1'b1;
    endcase
    if (jalr) e.pj = (rs1_data + imm) & 32'hFFFF_FFFE;
    else      e.pj = pc + imm;
    e.pw = pc + 32'd4;
    e.mp = (e.tk != pred_taken) || (e.tk && pred_taken && (e.pj != pred_target));
    e.rd = e.tk ? e.pj : e.pw;
    return e;
  endfunction

  // Scoreboard: inputs/outputs are stable at the falling edge
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected got tag=%0h required no result", res_tag);
        end else begin
          exp_t e;
          e = q.pop_front();
          n_deliv++;
          total++; if (res_tag !== e.tag) begin bad++; $display("FAIL sb_tag got=%0h required=%0h", res_tag, e.tag); end
          total++; if (taken !== e.tk) begin bad++; $display("FAIL sb_taken tag=%0h got=%0b required=%0b", e.tag, taken, e.tk); end
          total++; if (pc_jump !== e.pj) begin bad++; $display("FAIL sb_pc_jump tag=%0h got=%0h required=%0h", e.tag, pc_jump, e.pj); end
          total++; if (pc_wb !== e.pw) begin bad++; $display("FAIL sb_pc_wb tag=%0h got=%0h required=%0h", e.tag, pc_wb, e.pw); end
          total++; if (mispredict !== e.mp) begin bad++; $display("FAIL sb_mispredict tag=%0h got=%0b required=%0b", e.tag, mispredict, e.mp); end
          total++; if (redirect_pc !== e.rd) begin bad++; $display("FAIL sb_redirect tag=%0h got=%0h required=%0h", e.tag, redirect_pc, e.rd); end
        end
      end
      if (flush) q.delete();
      if (issue_valid && issue_ready && !flush) q.push_back(model());
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input logic [3:0] t, input logic [2:0] c, input logic j,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] p,
                        input logic pt, input logic [31:0] ptg);
    tag_in = t; cmp_ctrl = c; jalr = j; rs1_data = a; rs2_data = b;
    imm = im; pc = p; pred_taken = pt; pred_target = ptg; issue_valid = 1;
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%0b required=0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b required=0", busy); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL rst_issue_ready got=%0b required=1", issue_ready); end
    total++; if (pc_jump !== 32'h0 || redirect_pc !== 32'h0 || pc_wb !== 32'h0) begin
      bad++; $display("FAIL rst_pcs got=%0h/%0h/%0h required=0", pc_jump, pc_wb, redirect_pc); end
    total++; if (res_tag !== 4'h0 || taken !== 1'b0 || mispredict !== 1'b0) begin
      bad++; $display("FAIL rst_flags got tag=%0h taken=%0b misp=%0b required=0", res_tag, taken, mispredict); end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    mon_en = 1;
    step();
  endtask

  task automatic test_beq();
    res_ready = 1;
    set_op(4'h1, 3'b001, 1'b0, 32'd5, 32'd5, 32'h20, 32'h100, 1'b0, 32'h0);
    step();
    issue_valid = 0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL beq_early got res_valid=%0b required=0", res_valid); end
    step();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL beq_latency got res_valid=%0b required=1", res_valid); end
    total++; if (taken !== 1'b1) begin bad++; $display("FAIL beq_taken got=%0b required=1", taken); end
    total++; if (pc_jump !== 32'h120) begin bad++; $display("FAIL beq_pc_jump got=%0h required=120", pc_jump); end
    total++; if (pc_wb !== 32'h104) begin bad++; $display("FAIL beq_pc_wb got=%0h required=104", pc_wb); end
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL beq_mispredict got=%0b required=1", mispredict); end
    total++; if (redirect_pc !== 32'h120) begin bad++; $display("FAIL beq_redirect got=%0h required=120", redirect_pc); end
    step();
  endtask

  task automatic test_jalr();
    set_op(4'h2, 3'b111, 1'b1, 32'h2003, 32'h0, 32'h10, 32'h400, 1'b1, 32'h2012);
    step();
    issue_valid = 0;
    rs1_data = 32'h5000; imm = 32'h0;
    step();
    total++; if (res_tag !== 4'h2) begin bad++; $display("FAIL jalr_tag got=%0h required=2", res_tag); end
    total++; if (pc_jump !== 32'h2012) begin bad++; $display("FAIL jalr_pc_jump got=%0h required=2012", pc_jump); end
    total++; if (taken !== 1'b1) begin bad++; $display("FAIL jalr_taken got=%0b required=1", taken); end
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL jalr_mispredict got=%0b required=0", mispredict); end
    step();
  endtask

  task automatic test_signed();
    set_op(4'h3, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h200, 1'b1, 32'h208);
    step();
    set_op(4'h4, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h300, 1'b0, 32'h0);
    step();
    issue_valid = 0;
    total++; if (res_tag !== 4'h3 || taken !== 1'b1) begin bad++; $display("FAIL blt_signed got tag=%0h taken=%0b required tag=3 taken=1", res_tag, taken); end
    step();
    total++; if (res_tag !== 4'h4 || taken !== 1'b0) begin bad++; $display("FAIL bltu_unsigned got tag=%0h taken=%0b required tag=4 taken=0", res_tag, taken); end
    step();
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int c = 0;
    int base;
    logic saw_full = 0;
    logic acc;
    base = n_deliv;
    while (sent < 6 && c < 100) begin
      res_ready = !(c >= 3 && c < 8);
      if (!issue_valid)
        set_op(4'(8 + sent), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               $urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom);
      @(negedge clk);
      acc = issue_ready;
      if (!issue_ready) saw_full = 1;
      @(posedge clk); #1;
      c++;
      if (acc) begin sent++; issue_valid = 0; end
    end
    issue_valid = 0;
    while (c < 8) begin res_ready = 0; step(); c++; end
    res_ready = 1;
    for (int k = 0; k < 30 && q.size() != 0; k++) step();
    step();
    total++; if (saw_full !== 1'b1) begin bad++; $display("FAIL b2b_backpressure got issue_ready never 0 required a drop"); end
    total++; if (q.size() != 0) begin bad++; $display("FAIL b2b_drain_timeout got pending=%0d required=0", q.size()); end
    total++; if (n_deliv - base != 6) begin bad++; $display("FAIL b2b_count got=%0d required=6", n_deliv - base); end
  endtask

  task automatic test_flush();
    logic seen = 0;
    res_ready = 0;
    set_op(4'h5, 3'b001, 1'b0, 32'd1, 32'd1, 32'h40, 32'h500, 1'b1, 32'h540);
    step();
    set_op(4'h6, 3'b010, 1'b0, 32'd1, 32'd2, 32'h40, 32'h600, 1'b1, 32'h640);
    step();
    set_op(4'h7, 3'b111, 1'b0, 32'd0, 32'd0, 32'h40, 32'h700, 1'b1, 32'h740);
    flush = 1;
    step();
    flush = 0; issue_valid = 0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%0b required=0", busy); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL flush_res_valid got=%0b required=0", res_valid); end
    res_ready = 1;
    for (int k = 0; k < 5; k++) begin
      if (res_valid) seen = 1;
      step();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_ghost got result after flush required none"); end
  endtask

  task automatic test_reset_mid();
    logic seen = 0;
    logic rdy_ok = 1;
    res_ready = 0;
    set_op(4'h9, 3'b111, 1'b0, 32'h0, 32'h0, 32'h10, 32'h900, 1'b1, 32'h910);
    step();
    set_op(4'hA, 3'b001, 1'b0, 32'h3, 32'h3, 32'h10, 32'hA00, 1'b0, 32'h0);
    step();
    issue_valid = 0;
    #2;
    mon_en = 0;
    rst_n = 0;
    #1;
    q.delete();
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_valid got res_valid=%0b busy=%0b required 0/0", res_valid, busy); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL rstmid_issue_ready got=%0b required=1", issue_ready); end
    total++; if (res_tag !== 4'h0 || taken !== 1'b0 || mispredict !== 1'b0 || pc_jump !== 32'h0 || pc_wb !== 32'h0 || redirect_pc !== 32'h0) begin
      bad++; $display("FAIL rstmid_outputs got tag=%0h tk=%0b mp=%0b pj=%0h pw=%0h rd=%0h required 0", res_tag, taken, mispredict, pc_jump, pc_wb, redirect_pc); end
    @(negedge clk);
    rst_n = 1;
    mon_en = 1;
    res_ready = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (res_valid) seen = 1;
      if (!issue_ready) rdy_ok = 0;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_ghost got result after reset required none"); end
    total++; if (rdy_ok !== 1'b1) begin bad++; $display("FAIL rstmid_ready got issue_ready=0 required=1"); end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_jalr();
    test_signed();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a scenario never returns
  initial begin
    #200000;
    $display("FAIL global_timeout got no completion required finish");
    $fatal(1);
  end

endmodule
